mem_responder: RTL and testbench



---
 rtl/mem_pkg.sv | 14 +
 rtl/mem_responder_if.sv | 41 ++++
 rtl/mem_responder_sp_ram.sv | 52 +++++
 rtl/mem_responder.sv | 110 +++++++++++
 tb/tb_mem_responder.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared constants for the memory responder
//
// Purpose: default geometry and FSM state encoding shared by the memory
// responder, its bus interface and its RAM.
// Ports: none (package).
package mem_pkg;

    localparam int ADDR_WIDTH_DEF = 6;
    localparam int DATA_WIDTH_DEF = 16;

    localparam logic [0:0] ST_LOAD = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - CPU memory port and loader stream bundle
//
// Purpose: groups the CPU memory port, the valid/ready loader stream and the
// status outputs of the memory responder.
// Modports:
//   master - host/CPU side: drives mem_we/mem_addr/mem_data, load_valid/
//            load_data/load_last/load_start; observes mem_in, load_ready,
//            load_count, cpu_en.
//   slave  - memory responder side (the mirror image).
interface mem_responder_if
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;
    logic [DATA_WIDTH-1:0] mem_in;
    logic                  load_valid;
    logic                  load_ready;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  load_last;
    logic                  load_start;
    logic [ADDR_WIDTH:0]   load_count;
    logic                  cpu_en;

    modport master (
        output mem_we, mem_addr, mem_data,
        output load_valid, load_data, load_last, load_start,
        input  mem_in, load_ready, load_count, cpu_en
    );

    modport slave (
        input  mem_we, mem_addr, mem_data,
        input  load_valid, load_data, load_last, load_start,
        output mem_in, load_ready, load_count, cpu_en
    );

endinterface

// File: rtl/mem_responder_sp_ram.sv
// rtl/mem_responder_sp_ram.sv - single-port synchronous RAM
//
// Purpose: 2**ADDR_WIDTH x DATA_WIDTH single-port RAM with synchronous write
// and registered read. The read register only updates when re_i is high so
// the owner can hold its output; it resets to zero, the array does not.
// Configuration: MEM_WRITE_FIRST_EN selects write-first (read of the address
// being written returns the new data); default is read-first (old data).
// Ports:
//   clk, rst        clock, asynchronous active-high reset (read register only)
//   we_i            write enable
//   re_i            read enable (rdata_o holds when low)
//   addr_i          word address
//   wdata_i         write data
//   rdata_o         registered read data
module sp_ram #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [0:(2**ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Array is deliberately outside the reset so a program image survives rst.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
`ifdef MEM_WRITE_FIRST_EN
            rdata_q <= we_i ? wdata_i : mem_q[addr_i];
`else
            rdata_q <= mem_q[addr_i];
`endif
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - program/data memory with stream loader and CPU gate
//
// Purpose: 64 x 16 word memory serving the CPU memory port. After reset (or a
// load_start pulse) the block sits in LOAD, filling memory from the loader
// stream with the CPU held off; the final word (load_last, or memory full)
// moves it to RUN where the CPU owns the RAM and cpu_en is high.
// Configuration: MEM_WRITE_FIRST_EN (passed through to sp_ram) makes a CPU
// read of the address being written return the new data.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   bus        mem_responder_if.slave: CPU port (mem_we, mem_addr, mem_data,
//              mem_in), loader (load_valid, load_ready, load_data, load_last,
//              load_start, load_count) and cpu_en
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_responder_if.slave        bus
);

    logic [0:0]            state_q,      state_d;
    logic [ADDR_WIDTH-1:0] load_ptr_q,   load_ptr_d;
    logic [ADDR_WIDTH:0]   load_count_q, load_count_d;

    logic                  in_load;
    logic                  accept;
    logic                  ptr_full;

    logic                  ram_we;
    logic                  ram_re;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;

    assign in_load  = (state_q == ST_LOAD);
    assign accept   = in_load && bus.load_valid;
    assign ptr_full = (load_ptr_q == {ADDR_WIDTH{1'b1}});

    always_comb begin
        state_d      = state_q;
        load_ptr_d   = load_ptr_q;
        load_count_d = load_count_q;
        case (state_q)
            ST_LOAD: begin
                if (accept) begin
                    // Pointer wraps to 0 on the last slot; it is reset again
                    // before the next load so the wrap is harmless.
                    load_ptr_d   = load_ptr_q + 1'b1;
                    load_count_d = load_count_q + 1'b1;
                    if (bus.load_last || ptr_full) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (bus.load_start) begin
                    state_d      = ST_LOAD;
                    load_ptr_d   = '0;
                    load_count_d = '0;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_LOAD;
            load_ptr_q   <= '0;
            load_count_q <= '0;
        end else begin
            state_q      <= state_d;
            load_ptr_q   <= load_ptr_d;
            load_count_q <= load_count_d;
        end
    end

    // LOAD: the loader owns the RAM and the read register is frozen so mem_in
    // holds. RUN: the CPU owns it, including the load_start cycle, so a CPU
    // write issued alongside load_start still lands.
    assign ram_we    = in_load ? accept         : bus.mem_we;
    assign ram_re    = !in_load;
    assign ram_addr  = in_load ? load_ptr_q     : bus.mem_addr;
    assign ram_wdata = in_load ? bus.load_data  : bus.mem_data;

    sp_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    assign bus.mem_in     = ram_rdata;
    assign bus.load_ready = in_load;
    assign bus.load_count = load_count_q;
    assign bus.cpu_en     = (state_q == ST_RUN);

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - self-checking bench for mem_responder
module tb_mem_responder;

`ifdef MEM_WRITE_FIRST_EN
    localparam bit WF = 1'b1;
`else
    localparam bit WF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_responder_if bus ();

    mem_responder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural reference: memory contents, which words are defined,
    // loader progress, whether the CPU is running, and expected mem_in.
    logic [15:0] ref_mem [64];
    bit          known   [64];
    int          ref_ptr;
    int          ref_count;
    bit          ref_run;
    logic [15:0] exp_in;
    bit          exp_in_known;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_status(input string tag);
        chk({tag, "/cpu_en"},     32'(bus.cpu_en),     32'(ref_run));
        chk({tag, "/load_ready"}, 32'(bus.load_ready), 32'(!ref_run));
        chk({tag, "/load_count"}, 32'(bus.load_count), 32'(ref_count));
        if (exp_in_known) chk({tag, "/mem_in"}, 32'(bus.mem_in), 32'(exp_in));
    endtask

    // One loader handshake; mem_in must not move while loading.
    task automatic load_word(input logic [15:0] d, input bit last);
        chk("load/ready_before", 32'(bus.load_ready), 32'd1);
        bus.load_valid = 1'b1;
        bus.load_data  = d;
        bus.load_last  = last;
        tick();
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        ref_mem[ref_ptr] = d;
        known[ref_ptr]   = 1'b1;
        ref_count++;
        if (last || ref_ptr == 63) ref_run = 1'b1;
        ref_ptr = (ref_ptr + 1) % 64;
        chk_status("load");
    endtask

    // One RUN-mode CPU cycle with read of the same address.
    task automatic cpu_op(input bit we, input int a, input logic [15:0] d);
        bus.mem_we   = we;
        bus.mem_addr = 6'(a);
        bus.mem_data = d;
        tick();
        bus.mem_we = 1'b0;
        if (WF && we) begin
            exp_in = d;       exp_in_known = 1'b1;
        end else begin
            exp_in = ref_mem[a]; exp_in_known = known[a];
        end
        if (we) begin
            ref_mem[a] = d;
            known[a]   = 1'b1;
        end
        if (exp_in_known) chk($sformatf("cpu a=%0d we=%0d", a, we), 32'(bus.mem_in), 32'(exp_in));
    endtask

    task automatic pulse_load_start();
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        exp_in = ref_mem[bus.mem_addr];
        exp_in_known = known[bus.mem_addr];
        ref_run = 1'b0; ref_ptr = 0; ref_count = 0;
        chk_status("load_start");
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            ref_mem[i] = '0;
            known[i]   = 1'b0;
        end
        ref_ptr = 0; ref_count = 0; ref_run = 1'b0;
        exp_in = '0; exp_in_known = 1'b1;
        bus.mem_we = 0; bus.mem_addr = '0; bus.mem_data = '0;
        bus.load_valid = 0; bus.load_data = '0; bus.load_last = 0; bus.load_start = 0;

        // Reset state
        tick(); tick();
        chk_status("reset");
        rst = 1'b0;
        tick();
        chk_status("post_reset");

        // Three-word image
        load_word(16'h1111, 1'b0);
        load_word(16'h2222, 1'b0);
        load_word(16'h3333, 1'b1);
        chk("three/count", 32'(bus.load_count), 32'd3);
        cpu_op(1'b0, 1, 16'h0);
        chk("three/addr1", 32'(bus.mem_in), 32'h2222);

        // Random CPU traffic over a small window
        for (int i = 0; i < 24; i++) begin
            cpu_op(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 16'($urandom));
        end

        // load_start with a concurrent CPU write to addr 9
        bus.mem_we = 1'b1; bus.mem_addr = 6'd9; bus.mem_data = 16'h9A9A;
        bus.load_start = 1'b1;
        tick();
        bus.mem_we = 1'b0; bus.load_start = 1'b0;
        exp_in = WF ? 16'h9A9A : ref_mem[9];
        exp_in_known = WF | known[9];
        ref_mem[9] = 16'h9A9A; known[9] = 1'b1;
        ref_run = 1'b0; ref_ptr = 0; ref_count = 0;
        chk_status("start_with_write");

        // CPU port and load_start are ignored while loading
        bus.mem_we = 1'b1; bus.mem_addr = 6'd2; bus.mem_data = 16'hDEAD;
        bus.load_start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_status("load_ignore");
        end
        bus.load_start = 1'b0;

        // valid 1,0,1 with a stray last in the idle cycle
        load_word(16'($urandom), 1'b0);
        bus.load_last = 1'b1;
        tick();
        bus.load_last = 1'b0;
        chk_status("last_no_valid");
        bus.mem_we = 1'b0;
        load_word(16'($urandom), 1'b1);
        chk("toggle/count", 32'(bus.load_count), 32'd2);
        cpu_op(1'b0, 2, 16'h0);
        cpu_op(1'b0, 9, 16'h0);
        chk("toggle/addr9", 32'(bus.mem_in), 32'h9A9A);

        // Full 64-word image, last never set
        pulse_load_start();
        for (int i = 0; i < 64; i++) load_word(16'(i), 1'b0);
        chk("full/count", 32'(bus.load_count), 32'd64);
        chk("full/cpu_en", 32'(bus.cpu_en), 32'd1);
        cpu_op(1'b0, 63, 16'h0);
        chk("full/addr63", 32'(bus.mem_in), 32'h003F);
        for (int i = 0; i < 20; i++) begin
            cpu_op(1'($urandom_range(0, 1)), int'($urandom_range(0, 63)), 16'($urandom));
        end

        // Write then read, then same-cycle read/write of addr 5
        cpu_op(1'b1, 5, 16'hBEEF);
        cpu_op(1'b0, 5, 16'h0);
        chk("rw/read5", 32'(bus.mem_in), 32'hBEEF);
        cpu_op(1'b1, 5, 16'h1234);
        chk("rw/same_cycle", 32'(bus.mem_in), WF ? 32'h1234 : 32'hBEEF);

        // Single-word reload
        pulse_load_start();
        load_word(16'h7777, 1'b1);
        chk("reload/count", 32'(bus.load_count), 32'd1);
        cpu_op(1'b0, 0, 16'h0);
        chk("reload/addr0", 32'(bus.mem_in), 32'h7777);
        cpu_op(1'b0, 1, 16'h0);

        // Reset mid-load: async clear, words already written survive
        pulse_load_start();
        load_word(16'hAAAA, 1'b0);
        load_word(16'hBBBB, 1'b0);
        rst = 1'b1;
        #2;
        ref_ptr = 0; ref_count = 0; ref_run = 1'b0;
        exp_in = '0; exp_in_known = 1'b1;
        chk_status("async_reset");
        tick();
        rst = 1'b0;
        chk_status("after_reset");
        load_word(16'hCCCC, 1'b1);
        cpu_op(1'b0, 0, 16'h0);
        chk("rst/addr0", 32'(bus.mem_in), 32'hCCCC);
        cpu_op(1'b0, 1, 16'h0);
        chk("rst/addr1", 32'(bus.mem_in), 32'hBBBB);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
